// File: rtl/cmos_window_ctrl.sv
// Window/crop controller for the CMOS pixel path: frame-shadowed H/V crop window and mode word,
// with pixel data, data enable and vsync all leaving after the same fixed PIPE-cycle latency.
module cmos_window_ctrl #(
  parameter int               DATA_W    = 16,
  parameter int               CNT_W     = 12,
  parameter int               MODE_W    = 3,
  parameter int               PIPE      = 2,
  parameter logic             VS_POL    = 1'b1,
  parameter logic [CNT_W-1:0] H_OFF_RST = 12'd80,
  parameter logic [CNT_W-1:0] H_ACT_RST = 12'd320,
  parameter logic [CNT_W-1:0] V_OFF_RST = 12'd0,
  parameter logic [CNT_W-1:0] V_ACT_RST = 12'd480
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pdata_i,
  input  logic              de_i,
  input  logic              vs_i,
  input  logic [CNT_W-1:0]  h_offset_i,
  input  logic [CNT_W-1:0]  h_act_i,
  input  logic [CNT_W-1:0]  v_offset_i,
  input  logic [CNT_W-1:0]  v_act_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [DATA_W-1:0] pdata_o,
  output logic              de_o,
  output logic              vs_o,
  output logic [MODE_W-1:0] mode_o,
  output logic [7:0]        frame_cnt_o,
  output logic              line_short_o
);

  logic              vs_q;
  logic              de_q;
  logic              fs;
  logic              de_fall;
  logic [CNT_W-1:0]  x_cnt;
  logic [CNT_W-1:0]  y_cnt;
  logic [CNT_W-1:0]  h_off_s;
  logic [CNT_W-1:0]  h_act_s;
  logic [CNT_W-1:0]  v_off_s;
  logic [CNT_W-1:0]  v_act_s;
  logic [CNT_W:0]    h_end;
  logic [CNT_W:0]    v_end;
  logic              in_h;
  logic              in_v;
  logic              keep;
  logic              short_ev;
  logic [DATA_W-1:0] pd_pipe [PIPE];
  logic [PIPE-1:0]   de_pipe;
  logic [PIPE-1:0]   vs_pipe;
  logic [PIPE-1:0]   ls_pipe;

  assign fs      = (vs_q != VS_POL) && (vs_i == VS_POL);
  assign de_fall = de_q && !de_i;

  // One extra bit on the window end so offset+width never wraps back into range
  assign h_end    = {1'b0, h_off_s} + {1'b0, h_act_s};
  assign v_end    = {1'b0, v_off_s} + {1'b0, v_act_s};
  assign in_h     = (x_cnt >= h_off_s) && ({1'b0, x_cnt} < h_end);
  assign in_v     = (y_cnt >= v_off_s) && ({1'b0, y_cnt} < v_end);
  assign keep     = de_i && in_h && in_v;
  assign short_ev = de_fall && in_v && ({1'b0, x_cnt} < h_end);

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      h_off_s     <= H_OFF_RST;
      h_act_s     <= H_ACT_RST;
      v_off_s     <= V_OFF_RST;
      v_act_s     <= V_ACT_RST;
      mode_o      <= '0;
      frame_cnt_o <= '0;
    end else begin
      vs_q <= vs_i;
      de_q <= de_i;
      if (de_i) begin
        if (x_cnt != '1) x_cnt <= x_cnt + 1'b1;
      end else begin
        x_cnt <= '0;
      end
      if (fs) begin
        y_cnt       <= '0;
        h_off_s     <= h_offset_i;
        h_act_s     <= h_act_i;
        v_off_s     <= v_offset_i;
        v_act_s     <= v_act_i;
        mode_o      <= mode_i;
        frame_cnt_o <= frame_cnt_o + 8'd1;
      end else if (de_fall && (y_cnt != '1)) begin
        y_cnt <= y_cnt + 1'b1;
      end
    end
  end

  // Blanked pixels are zeroed on entry so pdata_o is already clean when de_o is low
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE; i++) pd_pipe[i] <= '0;
      de_pipe <= '0;
      vs_pipe <= '0;
      ls_pipe <= '0;
    end else begin
      pd_pipe[0] <= keep ? pdata_i : '0;
      de_pipe[0] <= keep;
      vs_pipe[0] <= vs_i;
      ls_pipe[0] <= short_ev;
      for (int i = 1; i < PIPE; i++) begin
        pd_pipe[i] <= pd_pipe[i-1];
        de_pipe[i] <= de_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        ls_pipe[i] <= ls_pipe[i-1];
      end
    end
  end

  assign pdata_o      = pd_pipe[PIPE-1];
  assign de_o         = de_pipe[PIPE-1];
  assign vs_o         = vs_pipe[PIPE-1];
  assign line_short_o = ls_pipe[PIPE-1];

endmodule

// File: tb/tb_cmos_window_ctrl.sv
// Directed bench for cmos_window_ctrl: drives 640-wide lines and vsync pulses, checks per-line
// crop statistics, latency, shadowing, mode/frame counter behaviour and mid-frame reset.
module tb_cmos_window_ctrl;
  localparam int PIPE = 2;
  localparam int GAP  = 8;
  localparam int W    = 640;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic [15:0] pdata_i;
  logic        de_i;
  logic        vs_i;
  logic [11:0] h_offset_i;
  logic [11:0] h_act_i;
  logic [11:0] v_offset_i;
  logic [11:0] v_act_i;
  logic [2:0]  mode_i;
  logic [15:0] pdata_o;
  logic        de_o;
  logic        vs_o;
  logic [2:0]  mode_o;
  logic [7:0]  frame_cnt_o;
  logic        line_short_o;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int r_nde, r_first, r_last, r_pdbad, r_nshort, r_short_step, r_vs_step;
  logic pre_de, rst_de;
  logic [15:0] rst_pd;

  cmos_window_ctrl dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .pdata_i(pdata_i), .de_i(de_i), .vs_i(vs_i),
    .h_offset_i(h_offset_i), .h_act_i(h_act_i), .v_offset_i(v_offset_i), .v_act_i(v_act_i),
    .mode_i(mode_i), .pdata_o(pdata_o), .de_o(de_o), .vs_o(vs_o), .mode_o(mode_o),
    .frame_cnt_o(frame_cnt_o), .line_short_o(line_short_o)
  );

  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [15:0] pix(input int ln, input int c);
    logic [31:0] a, b;
    a = ln;
    b = c;
    return {a[3:0], b[11:0]};
  endfunction

  task automatic set_win(input int ho, input int ha, input int vo, input int va);
    h_offset_i = 12'(ho); h_act_i = 12'(ha); v_offset_i = 12'(vo); v_act_i = 12'(va);
  endtask

  task automatic vsync();
    r_vs_step = -1;
    for (int s = 0; s < 8; s++) begin
      @(posedge pixel_clk); #1;
      if (vs_o && r_vs_step < 0) r_vs_step = s;
      vs_i = (s < 3);
    end
    exp_frames++;
  endtask

  // Output sampled at step s belongs to the column driven at step s-PIPE.
  task automatic run_line(input int width, input int ln, input int rst_at);
    r_nde = 0; r_first = -1; r_last = -1; r_pdbad = 0; r_nshort = 0; r_short_step = -1;
    for (int s = 0; s < width + GAP; s++) begin
      @(posedge pixel_clk); #1;
      if (de_o) begin
        r_nde++;
        if (r_first < 0) r_first = s - PIPE;
        r_last = s - PIPE;
        if (pdata_o !== pix(ln, s - PIPE)) r_pdbad++;
      end else if (pdata_o !== 16'h0) r_pdbad++;
      if (line_short_o) begin r_nshort++; r_short_step = s; end
      if (s == rst_at) begin
        pre_de = de_o; rst_n = 1'b0; #1;
        rst_de = de_o; rst_pd = pdata_o;
      end
      if (rst_at >= 0 && s == rst_at + 3) rst_n = 1'b1;
      de_i = (s < width);
      pdata_i = (s < width) ? pix(ln, s) : 16'h0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; de_i = 0; vs_i = 0; pdata_i = 0; mode_i = 0;
    set_win(80, 320, 0, 480);
    repeat (3) @(posedge pixel_clk);
    #1;
    checks++; if (de_o !== 1'b0) begin errors++; $display("FAIL rst_de got %0d exp 0", de_o); end
    checks++; if (pdata_o !== 16'h0) begin errors++; $display("FAIL rst_pdata got %0h exp 0", pdata_o); end
    checks++; if (vs_o !== 1'b0) begin errors++; $display("FAIL rst_vs got %0d exp 0", vs_o); end
    checks++; if (frame_cnt_o !== 8'd0) begin errors++; $display("FAIL rst_frame got %0d exp 0", frame_cnt_o); end
    checks++; if (mode_o !== 3'd0) begin errors++; $display("FAIL rst_mode got %0d exp 0", mode_o); end
    checks++; if (line_short_o !== 1'b0) begin errors++; $display("FAIL rst_short got %0d exp 0", line_short_o); end
    rst_n = 1'b1;
    vsync();
    checks++; if (r_vs_step !== PIPE) begin errors++; $display("FAIL vs_latency got %0d exp %0d", r_vs_step, PIPE); end
    checks++; if (frame_cnt_o !== 8'd1) begin errors++; $display("FAIL frame_after_fs got %0d exp 1", frame_cnt_o); end
  endtask

  task automatic test_default_window();
    for (int ln = 0; ln < 4; ln++) begin
      run_line(W, ln, -1);
      checks++; if (r_nde != 320) begin errors++; $display("FAIL def_nde l%0d got %0d exp 320", ln, r_nde); end
      checks++; if (r_first != 80) begin errors++; $display("FAIL def_first l%0d got %0d exp 80", ln, r_first); end
      checks++; if (r_last != 399) begin errors++; $display("FAIL def_last l%0d got %0d exp 399", ln, r_last); end
      checks++; if (r_pdbad != 0) begin errors++; $display("FAIL def_pdata l%0d got %0d bad exp 0", ln, r_pdbad); end
      checks++; if (r_nshort != 0) begin errors++; $display("FAIL def_short l%0d got %0d exp 0", ln, r_nshort); end
    end
  endtask

  task automatic test_v_window();
    int en;
    set_win(0, 640, 1, 2);
    vsync();
    for (int ln = 0; ln < 4; ln++) begin
      en = (ln == 1 || ln == 2) ? 640 : 0;
      run_line(W, ln, -1);
      checks++; if (r_nde != en) begin errors++; $display("FAIL vwin_nde l%0d got %0d exp %0d", ln, r_nde, en); end
      checks++; if (r_pdbad != 0) begin errors++; $display("FAIL vwin_pdata l%0d got %0d bad exp 0", ln, r_pdbad); end
      if (en != 0) begin
        checks++; if (r_first != 0) begin errors++; $display("FAIL vwin_first l%0d got %0d exp 0", ln, r_first); end
        checks++; if (r_last != 639) begin errors++; $display("FAIL vwin_last l%0d got %0d exp 639", ln, r_last); end
      end
    end
  endtask

  task automatic test_shadow();
    set_win(80, 320, 0, 480);
    vsync();
    run_line(W, 0, -1);
    h_offset_i = 12'd100;
    run_line(W, 1, -1);
    checks++; if (r_first != 80) begin errors++; $display("FAIL shadow_mid got %0d exp 80", r_first); end
    vsync();
    run_line(W, 0, -1);
    checks++; if (r_first != 100) begin errors++; $display("FAIL shadow_next got %0d exp 100", r_first); end
    checks++; if (r_last != 419) begin errors++; $display("FAIL shadow_last got %0d exp 419", r_last); end
  endtask

  task automatic test_short_line();
    set_win(600, 100, 0, 480);
    vsync();
    for (int ln = 0; ln < 2; ln++) begin
      run_line(W, ln, -1);
      checks++; if (r_nde != 40) begin errors++; $display("FAIL short_nde l%0d got %0d exp 40", ln, r_nde); end
      checks++; if (r_first != 600) begin errors++; $display("FAIL short_first l%0d got %0d exp 600", ln, r_first); end
      checks++; if (r_last != 639) begin errors++; $display("FAIL short_last l%0d got %0d exp 639", ln, r_last); end
      checks++; if (r_nshort != 1) begin errors++; $display("FAIL short_pulses l%0d got %0d exp 1", ln, r_nshort); end
      checks++; if (r_short_step != W + PIPE) begin errors++; $display("FAIL short_pos l%0d got %0d exp %0d", ln, r_short_step, W + PIPE); end
    end
    set_win(0, 0, 0, 480);
    vsync();
    run_line(W, 0, -1);
    checks++; if (r_nde != 0) begin errors++; $display("FAIL hact0_nde got %0d exp 0", r_nde); end
    checks++; if (r_vs_step !== PIPE) begin errors++; $display("FAIL hact0_vs got %0d exp %0d", r_vs_step, PIPE); end
  endtask

  task automatic test_mode_wrap();
    set_win(80, 320, 0, 480);
    mode_i = 3'd2;
    vsync();
    checks++; if (mode_o !== 3'd2) begin errors++; $display("FAIL mode_load got %0d exp 2", mode_o); end
    run_line(W, 0, -1);
    mode_i = 3'd5;
    run_line(W, 1, -1);
    checks++; if (mode_o !== 3'd2) begin errors++; $display("FAIL mode_mid got %0d exp 2", mode_o); end
    vsync();
    checks++; if (mode_o !== 3'd5) begin errors++; $display("FAIL mode_next got %0d exp 5", mode_o); end
    checks++; if (frame_cnt_o !== 8'(exp_frames)) begin errors++; $display("FAIL frame_cnt got %0d exp %0d", frame_cnt_o, exp_frames); end
    while ((exp_frames % 256) != 255) vsync();
    checks++; if (frame_cnt_o !== 8'd255) begin errors++; $display("FAIL frame_255 got %0d exp 255", frame_cnt_o); end
    vsync();
    checks++; if (frame_cnt_o !== 8'd0) begin errors++; $display("FAIL frame_wrap got %0d exp 0", frame_cnt_o); end
  endtask

  task automatic test_reset_mid();
    set_win(0, 640, 0, 480);
    mode_i = 3'd3;
    vsync();
    run_line(W, 0, -1);
    checks++; if (r_nde != 640) begin errors++; $display("FAIL prerst_nde got %0d exp 640", r_nde); end
    run_line(W, 1, 200);
    checks++; if (pre_de !== 1'b1) begin errors++; $display("FAIL prerst_de got %0d exp 1", pre_de); end
    checks++; if (rst_de !== 1'b0) begin errors++; $display("FAIL midrst_de got %0d exp 0", rst_de); end
    checks++; if (rst_pd !== 16'h0) begin errors++; $display("FAIL midrst_pdata got %0h exp 0", rst_pd); end
    exp_frames = 0;
    checks++; if (mode_o !== 3'd0) begin errors++; $display("FAIL midrst_mode got %0d exp 0", mode_o); end
    checks++; if (frame_cnt_o !== 8'd0) begin errors++; $display("FAIL midrst_frame got %0d exp 0", frame_cnt_o); end
    run_line(W, 2, -1);
    checks++; if (r_nde != 320) begin errors++; $display("FAIL postrst_nde got %0d exp 320", r_nde); end
    checks++; if (r_first != 80) begin errors++; $display("FAIL postrst_first got %0d exp 80", r_first); end
    checks++; if (r_pdbad != 0) begin errors++; $display("FAIL postrst_pdata got %0d bad exp 0", r_pdbad); end
    vsync();
    run_line(W, 0, -1);
    checks++; if (r_nde != 640) begin errors++; $display("FAIL postrst_fs_nde got %0d exp 640", r_nde); end
    checks++; if (frame_cnt_o !== 8'd1) begin errors++; $display("FAIL postrst_fs_frame got %0d exp 1", frame_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_default_window();
    test_v_window();
    test_shadow();
    test_short_line();
    test_mode_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
